div_pipe_param: RTL and testbench



---
 rtl/div_pipe_param.sv | 180 ++++++++++++++++++
 tb/tb_div_pipe_param.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_pipe_param.sv
// Parametrised pipelined restoring divider with valid/ready handshake, tag pass-through and dbz/ovf flags.
// Latency: a transfer at edge t shows out_valid after edge t+S (S = ceil(N/BPS)), plus one cycle per stall cycle.
// Backpressure: global stall; every stage, bubbles included, holds while out_valid & ~out_ready, and in_ready follows.
// Optional build macro DIV_ROUND_EN: round quotient to nearest (half away from zero) in the final stage.
module div_pipe_param #(
  parameter int N      = 36,
  parameter int BPS    = 9,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     q,
  output logic [N-1:0]     r,
  output logic [TAG_W-1:0] tag_out,
  output logic             dbz,
  output logic             ovf
);

  // Stage count and width of the first (possibly narrower) stage.
  localparam int S = (N + BPS - 1) / BPS;
  localparam int F = N - (S - 1) * BPS;

  // Index 0 is the operand capture register (magnitudes already taken);
  // indices 1..S are the restoring stages, S being the output register.
  logic [S:0]       vld_r;
  logic [N-1:0]     rem_r [0:S];
  logic [N-1:0]     quo_r [0:S];
  logic [N-1:0]     dvd_r [0:S];
  logic [N-1:0]     dsr_r [0:S];
  logic [TAG_W-1:0] tag_r [0:S];
  logic             nq_r  [0:S];
  logic             nr_r  [0:S];
  logic             dbz_r [0:S];
  logic             ovf_r [0:S];

  logic [N-1:0]     rem_n [0:S];
  logic [N-1:0]     quo_n [0:S];
  logic [N-1:0]     dvd_n [0:S];
  logic [N-1:0]     dsr_n [0:S];
  logic [TAG_W-1:0] tag_n [0:S];
  logic             nq_n  [0:S];
  logic             nr_n  [0:S];
  logic             dbz_n [0:S];
  logic             ovf_n [0:S];

  logic en;

  assign out_valid = vld_r[S];
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign q         = quo_r[S];
  assign r         = rem_r[S];
  assign tag_out   = tag_r[S];
  assign dbz       = vld_r[S] & dbz_r[S];
  assign ovf       = vld_r[S] & ovf_r[S];

  // Operand conditioning, per-stage restoring steps and final sign/rounding fix-up.
  always_comb begin : stage_logic
    logic         sgn_a;
    logic         sgn_b;
    logic [N-1:0] rem;
    logic [N-1:0] dvd;
    logic [N-1:0] quo;
    logic [N-1:0] qm;
    logic [N:0]   tr;
`ifdef DIV_ROUND_EN
    logic [N:0]   qm1;
    logic         inc;
    qm1 = '0;
    inc = 1'b0;
`endif
    rem = '0;
    dvd = '0;
    quo = '0;
    qm  = '0;
    tr  = '0;

    // Capture: work on magnitudes, remember the result signs.
    sgn_a    = (SIGNED != 0) && a[N-1];
    sgn_b    = (SIGNED != 0) && b[N-1];
    rem_n[0] = '0;
    quo_n[0] = '0;
    dvd_n[0] = sgn_a ? -a : a;
    dsr_n[0] = sgn_b ? -b : b;
    tag_n[0] = tag_in;
    nq_n[0]  = sgn_a ^ sgn_b;
    nr_n[0]  = sgn_a;
    dbz_n[0] = (b == '0);
    ovf_n[0] = (SIGNED != 0) && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);

    for (int k = 1; k <= S; k++) begin
      rem = rem_r[k-1];
      dvd = dvd_r[k-1];
      quo = quo_r[k-1];
      // Stage 1 resolves only F bits so that later stages all take BPS.
      for (int j = 0; j < BPS; j++) begin
        if (k > 1 || j < F) begin
          tr = {rem, dvd[N-1]};
          if (tr >= {1'b0, dsr_r[k-1]}) begin
            tr  = tr - {1'b0, dsr_r[k-1]};
            quo = {quo[N-2:0], 1'b1};
          end else begin
            quo = {quo[N-2:0], 1'b0};
          end
          rem = tr[N-1:0];
          dvd = {dvd[N-2:0], 1'b0};
        end
      end
      rem_n[k] = rem;
      quo_n[k] = quo;
      dvd_n[k] = dvd;
      dsr_n[k] = dsr_r[k-1];
      tag_n[k] = tag_r[k-1];
      nq_n[k]  = nq_r[k-1];
      nr_n[k]  = nr_r[k-1];
      dbz_n[k] = dbz_r[k-1];
      ovf_n[k] = ovf_r[k-1];

      if (k == S) begin
        qm = quo;
`ifdef DIV_ROUND_EN
        // Half away from zero on the magnitude; r keeps the truncated value.
        inc = !dbz_r[k-1] && ({rem, 1'b0} >= {1'b0, dsr_r[k-1]});
        qm1 = {1'b0, quo} + {{N{1'b0}}, 1'b1};
        if (inc) begin
          if (SIGNED == 0) begin
            qm = (&quo) ? quo : qm1[N-1:0];
          end else if (!nq_r[k-1] && (qm1 > {2'b00, {(N-1){1'b1}}})) begin
            qm       = {1'b0, {(N-1){1'b1}}};
            ovf_n[k] = 1'b1;
          end else begin
            qm = qm1[N-1:0];
          end
        end
`endif
        quo_n[k] = nq_r[k-1] ? -qm : qm;
        rem_n[k] = nr_r[k-1] ? -rem : rem;
        // Divide by zero: fixed quotient, remainder is the dividend.
        if (dbz_r[k-1]) begin
          quo_n[k] = ((SIGNED != 0) && nr_r[k-1]) ? {{(N-1){1'b0}}, 1'b1} : '1;
        end
      end
    end
  end

  // Valid bits: cleared by reset, shifted on every enabled cycle (bubbles too).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= '0;
    end else if (en) begin
      vld_r <= {vld_r[S-1:0], in_valid};
    end
  end

  // Data registers: no reset, advance together with the valid bits.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k <= S; k++) begin
        rem_r[k] <= rem_n[k];
        quo_r[k] <= quo_n[k];
        dvd_r[k] <= dvd_n[k];
        dsr_r[k] <= dsr_n[k];
        tag_r[k] <= tag_n[k];
        nq_r[k]  <= nq_n[k];
        nr_r[k]  <= nr_n[k];
        dbz_r[k] <= dbz_n[k];
        ovf_r[k] <= ovf_n[k];
      end
    end
  end

endmodule

// File: tb/tb_div_pipe_param.sv
// Bench for div_pipe_param: default unsigned instance plus a signed N=16/BPS=5 instance.
// Expected results come from a plain-arithmetic reference model and an in-order scoreboard.
// Honours DIV_ROUND_EN in the reference model when the design is built with it.
module tb_div_pipe_param;
  localparam int N0 = 36;
  localparam int S0 = 4;
  localparam int N1 = 16;
  localparam int S1 = 4;
  localparam int TW = 4;
  localparam logic [63:0] MAXU0 = 64'hF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          iv0 = 1'b0, ir0, ov0, dbz0, ovf0;
  logic          or0 = 1'b1;
  logic [N0-1:0] a0 = '0, b0 = '0, q0, r0;
  logic [TW-1:0] tg0 = '0, tgo0;

  logic          iv1 = 1'b0, ir1, ov1, dbz1, ovf1;
  logic          or1 = 1'b1;
  logic [N1-1:0] a1 = '0, b1 = '0, q1, r1;
  logic [TW-1:0] tg1 = '0, tgo1;

  logic rdy_low = 1'b0;
  logic rdy_rand = 1'b0;

  int chk_cnt = 0;
  int err_cnt = 0;
  int got0 = 0;
  int hold_cnt = 0;

  typedef struct packed {
    logic [63:0]   q;
    logic [63:0]   r;
    logic [TW-1:0] tag;
    logic          dbz;
    logic          ovf;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  div_pipe_param dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .tag_in(tg0),
    .out_valid(ov0), .out_ready(or0), .q(q0), .r(r0), .tag_out(tgo0), .dbz(dbz0), .ovf(ovf0)
  );

  div_pipe_param #(.N(N1), .BPS(5), .SIGNED(1), .TAG_W(TW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .tag_in(tg1),
    .out_valid(ov1), .out_ready(or1), .q(q1), .r(r1), .tag_out(tgo1), .dbz(dbz1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Unsigned reference: floor division, b=0 gives all ones / r=a.
  function automatic exp_t model_u(input logic [N0-1:0] a, input logic [N0-1:0] b, input logic [TW-1:0] t);
    exp_t e;
    logic [63:0] aa;
    logic [63:0] bb;
    aa = 64'(a);
    bb = 64'(b);
    e.tag = t;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (bb == 64'd0) begin
      e.q = MAXU0;
      e.r = aa;
      e.dbz = 1'b1;
    end else begin
      e.q = aa / bb;
      e.r = aa % bb;
`ifdef DIV_ROUND_EN
      if (2 * e.r >= bb) e.q = (e.q == MAXU0) ? MAXU0 : e.q + 64'd1;
`endif
    end
    return e;
  endfunction

  // Signed reference on 16-bit two's complement using native truncating division.
  function automatic exp_t model_s(input logic [N1-1:0] a, input logic [N1-1:0] b, input logic [TW-1:0] t);
    exp_t e;
    longint sa;
    longint sb;
    longint qv;
    longint rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.tag = t;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (sb == 0) begin
      qv = (sa < 0) ? 1 : -1;
      rv = sa;
      e.dbz = 1'b1;
    end else if (sa == -32768 && sb == -1) begin
      qv = -32768;
      rv = 0;
      e.ovf = 1'b1;
    end else begin
      qv = sa / sb;
      rv = sa % sb;
`ifdef DIV_ROUND_EN
      begin
        longint aq, ar, ab;
        aq = (qv < 0) ? -qv : qv;
        ar = (rv < 0) ? -rv : rv;
        ab = (sb < 0) ? -sb : sb;
        if (2 * ar >= ab) begin
          aq = aq + 1;
          qv = ((sa < 0) != (sb < 0)) ? -aq : aq;
          if (qv > 32767) begin
            qv = 32767;
            e.ovf = 1'b1;
          end
        end
      end
`endif
    end
    e.q = {48'd0, qv[15:0]};
    e.r = {48'd0, rv[15:0]};
    return e;
  endfunction

  // Output-ready driver for the unsigned instance (sole writer of or0).
  always @(posedge clk) begin
    #2;
    or0 = rdy_low ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Scoreboard and hold-stability monitor for the unsigned instance.
  logic          held = 1'b0;
  logic [N0-1:0] hq, hr;
  logic [TW-1:0] ht;
  logic          hd;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb0.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check_val("hold_vld", ov0, 1);
        check_val("hold_q", q0, hq);
        check_val("hold_r", r0, hr);
        check_val("hold_tag", tgo0, ht);
        check_val("hold_dbz", dbz0, hd);
      end
      if (ov0 && !or0) begin
        check_val("in_rdy_hold", ir0, 0);
        held = 1'b1;
        hq = q0; hr = r0; ht = tgo0; hd = dbz0;
        hold_cnt++;
      end else begin
        held = 1'b0;
      end
      if (iv0 && ir0) sb0.push_back(model_u(a0, b0, tg0));
      if (ov0 && or0) begin
        if (sb0.size() == 0) begin
          check_val("spurious0", 1, 0);
        end else begin
          exp_t e;
          e = sb0.pop_front();
          check_val("u_q", q0, e.q);
          check_val("u_r", r0, e.r);
          check_val("u_tag", tgo0, e.tag);
          check_val("u_dbz", dbz0, e.dbz);
          check_val("u_ovf", ovf0, e.ovf);
          got0++;
        end
      end
    end
  end

  // Scoreboard for the signed instance (always ready).
  always @(negedge clk) begin
    if (!rst_n) begin
      sb1.delete();
    end else begin
      if (iv1 && ir1) sb1.push_back(model_s(a1, b1, tg1));
      if (ov1) begin
        if (sb1.size() == 0) begin
          check_val("spurious1", 1, 0);
        end else begin
          exp_t e;
          e = sb1.pop_front();
          check_val("s_q", {48'd0, q1}, e.q);
          check_val("s_r", {48'd0, r1}, e.r);
          check_val("s_tag", tgo1, e.tag);
          check_val("s_dbz", dbz1, e.dbz);
          check_val("s_ovf", ovf1, e.ovf);
        end
      end
    end
  end

  task automatic send0(input logic [N0-1:0] a, input logic [N0-1:0] b, input logic [TW-1:0] t);
    int n;
    logic ok;
    n = 0;
    iv0 = 1'b1; a0 = a; b0 = b; tg0 = t;
    do begin
      @(negedge clk);
      ok = ir0;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check_val("send0_timeout", 0, 1);
    iv0 = 1'b0;
  endtask

  task automatic send1(input logic [N1-1:0] a, input logic [N1-1:0] b, input logic [TW-1:0] t);
    int n;
    logic ok;
    n = 0;
    iv1 = 1'b1; a1 = a; b1 = b; tg1 = t;
    do begin
      @(negedge clk);
      ok = ir1;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check_val("send1_timeout", 0, 1);
    iv1 = 1'b0;
  endtask

  // Edges after the transfer edge until out_valid is seen.
  task automatic wait_out0(output int lat);
    lat = 0;
    @(negedge clk);
    while (!ov0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!ov0) check_val("wait_out0", 0, 1);
  endtask

  task automatic wait_out1(output int lat);
    lat = 0;
    @(negedge clk);
    while (!ov1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!ov1) check_val("wait_out1", 0, 1);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check_val("drain0", sb0.size(), 0);
    check_val("drain1", sb1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int g0;
    int seen;
    logic [63:0] rnd;
    logic [N0-1:0] ra, rb;
    logic [N1-1:0] sa, sb;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_rdy", ir0, 1);
    check_val("rst_out_vld", ov0, 0);
    check_val("rst_dbz", dbz0, 0);
    check_val("rst_ovf", ovf0, 0);
    check_val("rst_out_vld1", ov1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic latency and result.
    send0(36'd100, 36'd7, 4'd3);
    wait_out0(lat);
    check_val("lat0", lat, S0);
    check_val("t1_q", q0, 14);
    check_val("t1_r", r0, 2);
    check_val("t1_tag", tgo0, 3);
    check_val("t1_dbz", dbz0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Max dividend then divide-by-zero, back to back.
    send0(MAXU0[N0-1:0], 36'd1, 4'd5);
    send0(36'd5, 36'd0, 4'd6);
    wait_out0(lat);
    check_val("t2_q_max", q0, MAXU0);
    check_val("t2_r_max", r0, 0);
    check_val("t2_dbz_max", dbz0, 0);
    @(negedge clk);
    check_val("t2_vld_dbz", ov0, 1);
    check_val("t2_q_dbz", q0, MAXU0);
    check_val("t2_r_dbz", r0, 5);
    check_val("t2_dbz", dbz0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Rounding sensitive case.
    send0(36'd7, 36'd2, 4'd1);
    wait_out0(lat);
`ifdef DIV_ROUND_EN
    check_val("t_round_q", q0, 4);
`else
    check_val("t_round_q", q0, 3);
`endif
    check_val("t_round_r", r0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Stream of 8 with a stall window on the output.
    g0 = got0;
    hold_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send0(N0'(i * 10), 36'd3, TW'(i));
      end
      begin
        repeat (2) @(posedge clk);
        #1 rdy_low = 1'b1;
        repeat (5) @(posedge clk);
        #1 rdy_low = 1'b0;
      end
    join
    drain();
    check_val("stream_count", got0 - g0, 8);
    check_val("stream_held", hold_cnt > 0, 1);

    // Reset with three operations in flight.
    send0(36'd1007, 36'd2, 4'd9);
    send0(36'd2007, 36'd3, 4'd10);
    send0(36'd3007, 36'd4, 4'd11);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_mid_vld", ov0, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov0) seen++;
    end
    check_val("rst_flush", seen, 0);
    @(posedge clk);
    #1;

    // Randomised unsigned traffic with random output back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rnd = {$urandom(), $urandom()};
      ra = rnd[N0-1:0];
      rnd = {$urandom(), $urandom()};
      rb = rnd[N0-1:0] >> $urandom_range(0, N0 - 1);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 36'd1;
        2: ra = MAXU0[N0-1:0];
        3: rb = N0'($urandom_range(2, 9));
        default: ;
      endcase
      send0(ra, rb, TW'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_rand = 1'b0;
    drain();

    // Signed instance: directed cases.
    send1(-16'sd7, 16'sd2, 4'd2);
    wait_out1(lat);
    check_val("lat1", lat, S1);
    check_val("s_m7_q", {48'd0, q1}, 64'h0000_0000_0000_FFFD);
    check_val("s_m7_r", {48'd0, r1}, 64'h0000_0000_0000_FFFF);
    @(posedge clk);
    #1;
    send1(16'h8000, 16'hFFFF, 4'd4);
    wait_out1(lat);
    check_val("s_ovf_q", {48'd0, q1}, 64'h8000);
    check_val("s_ovf_r", {48'd0, r1}, 0);
    check_val("s_ovf_flag", ovf1, 1);
    @(posedge clk);
    #1;
    send1(-16'sd7, 16'sd0, 4'd6);
    wait_out1(lat);
    check_val("s_dbz_q", {48'd0, q1}, 1);
    check_val("s_dbz_r", {48'd0, r1}, 64'hFFF9);
    check_val("s_dbz_flag", dbz1, 1);
    @(posedge clk);
    #1;

    // Signed instance: randomised traffic.
    for (int i = 0; i < 200; i++) begin
      sa = N1'($urandom());
      sb = N1'($urandom());
      case ($urandom_range(0, 7))
        0: sb = '0;
        1: sb = 16'hFFFF;
        2: sa = 16'h8000;
        3: sb = ($urandom_range(0, 1) != 0) ? N1'($urandom_range(1, 20)) : -N1'($urandom_range(1, 20));
        4: sb = sb >> $urandom_range(0, 15);
        default: ;
      endcase
      send1(sa, sb, TW'($urandom_range(0, 15)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
